// File: rtl/alarm_ringer_pkg.sv
// alarm_ringer_pkg
//   Shared definitions for the alarm ringer slice: FSM state encodings,
//   default timing constants for a 50 MHz system clock, and a helper that
//   sizes counters from their terminal count.
//   No ports (package).
package alarm_ringer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam int DEF_TONE_DIV    = 12500;      // 2 kHz tone half-period
   localparam int DEF_CADENCE_DIV = 12500000;   // 0.25 s beep on/off half-period
   localparam int DEF_RING_SEC    = 60;
   localparam int DEF_SNOOZE_SEC  = 300;
   localparam int DEF_MAX_SNOOZE  = 3;

   // Width of a counter that holds 0..limit-1; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      if (limit < 2) begin
         return 1;
      end else begin
         return $clog2(limit);
      end
   endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen
//   Tone and cadence generator for the buzzer. While run is high a tone
//   square wave (half-period TONE_DIV cycles) is gated on/off by a cadence
//   square wave (half-period CADENCE_DIV cycles). While run is low every
//   counter is held cleared, gate=1, tone=0 and the output is 0.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   run   in  high while the alarm is ringing
//   buzz  out registered tone & gate (one cycle behind tone/gate state)
module alarm_tone_gen
   import alarm_ringer_pkg::*;
#(
   parameter int TONE_DIV    = DEF_TONE_DIV,
   parameter int CADENCE_DIV = DEF_CADENCE_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic buzz
);

   localparam int TONE_W = cnt_width(TONE_DIV);
   localparam int CAD_W  = cnt_width(CADENCE_DIV);

   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
   localparam logic [TONE_W-1:0] TONE_ONE  = TONE_W'(1);
   localparam logic [CAD_W-1:0]  CAD_LAST  = CAD_W'(CADENCE_DIV - 1);
   localparam logic [CAD_W-1:0]  CAD_ONE   = CAD_W'(1);

   logic [TONE_W-1:0] tone_cnt_r;
   logic [CAD_W-1:0]  cad_cnt_r;
   logic              tone_r;
   logic              gate_r;
   logic              buzz_r;

   // Tone/cadence counters, their square waves, and the gated buzzer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tone_cnt_r <= '0;
         cad_cnt_r  <= '0;
         tone_r     <= 1'b0;
         gate_r     <= 1'b1;
         buzz_r     <= 1'b0;
      end else if (!run) begin
         tone_cnt_r <= '0;
         cad_cnt_r  <= '0;
         tone_r     <= 1'b0;
         gate_r     <= 1'b1;
         buzz_r     <= 1'b0;
      end else begin
         if (tone_cnt_r == TONE_LAST) begin
            tone_cnt_r <= '0;
            tone_r     <= ~tone_r;
         end else begin
            tone_cnt_r <= tone_cnt_r + TONE_ONE;
         end
         if (cad_cnt_r == CAD_LAST) begin
            cad_cnt_r <= '0;
            gate_r    <= ~gate_r;
         end else begin
            cad_cnt_r <= cad_cnt_r + CAD_ONE;
         end
         // Uses the pre-edge tone/gate, hence the one-cycle lag.
         buzz_r <= tone_r & gate_r;
      end
   end

   assign buzz = buzz_r;

endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer
//   Consumer end of the alarm enable line. A time-match pulse (with the
//   alarm enabled) starts ringing; the user can stop or snooze (a bounded
//   number of times per alarm event), and an unattended ring ends after
//   RING_SEC seconds. The buzzer pattern comes from alarm_tone_gen.
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   alarm_en    in  alarm enable level
//   match       in  one-cycle pulse, current time == alarm time
//   sec_tick    in  one-cycle 1 Hz pulse
//   stop_key    in  one-cycle stop press
//   snooze_key  in  one-cycle snooze press
//   buzzer      out registered buzzer drive
//   ringing     out high while in RING
//   snoozing    out high while in SNOOZE
module alarm_ringer
   import alarm_ringer_pkg::*;
#(
   parameter int TONE_DIV    = DEF_TONE_DIV,
   parameter int CADENCE_DIV = DEF_CADENCE_DIV,
   parameter int RING_SEC    = DEF_RING_SEC,
   parameter int SNOOZE_SEC  = DEF_SNOOZE_SEC,
   parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
   input  logic clk,
   input  logic rst,
   input  logic alarm_en,
   input  logic match,
   input  logic sec_tick,
   input  logic stop_key,
   input  logic snooze_key,
   output logic buzzer,
   output logic ringing,
   output logic snoozing
);

   localparam int RING_W = cnt_width(RING_SEC);
   localparam int SSEC_W = cnt_width(SNOOZE_SEC);
   localparam int SCNT_W = cnt_width(MAX_SNOOZE + 1);   // holds 0..MAX_SNOOZE

   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
   localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
   localparam logic [SSEC_W-1:0] SSEC_LAST = SSEC_W'(SNOOZE_SEC - 1);
   localparam logic [SSEC_W-1:0] SSEC_ONE  = SSEC_W'(1);
   localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(MAX_SNOOZE);
   localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

   state_t            state_r;
   logic [RING_W-1:0] ring_sec_r;
   logic [SSEC_W-1:0] snooze_sec_r;
   logic [SCNT_W-1:0] snooze_cnt_r;
   logic              ringing_r;
   logic              snoozing_r;
   logic              run_s;

   // Ring/snooze FSM with second counters; ringing/snoozing track the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         ring_sec_r   <= '0;
         snooze_sec_r <= '0;
         snooze_cnt_r <= '0;
         ringing_r    <= 1'b0;
         snoozing_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (alarm_en && !stop_key && match) begin
                  // A sec_tick in this cycle is deliberately not counted.
                  state_r      <= ST_RING;
                  ringing_r    <= 1'b1;
                  snoozing_r   <= 1'b0;
                  ring_sec_r   <= '0;
                  snooze_sec_r <= '0;
                  snooze_cnt_r <= '0;
               end else begin
                  state_r    <= ST_IDLE;
                  ringing_r  <= 1'b0;
                  snoozing_r <= 1'b0;
               end
            end
            ST_RING: begin
               if (!alarm_en || stop_key) begin
                  state_r    <= ST_IDLE;
                  ringing_r  <= 1'b0;
                  snoozing_r <= 1'b0;
                  ring_sec_r <= '0;
               end else if (snooze_key && (snooze_cnt_r < SCNT_MAX)) begin
                  // Snooze wins over a coincident timeout tick.
                  state_r      <= ST_SNOOZE;
                  ringing_r    <= 1'b0;
                  snoozing_r   <= 1'b1;
                  snooze_cnt_r <= snooze_cnt_r + SCNT_ONE;
                  snooze_sec_r <= '0;
                  ring_sec_r   <= '0;
               end else if (sec_tick) begin
                  if (ring_sec_r == RING_LAST) begin
                     state_r    <= ST_IDLE;
                     ringing_r  <= 1'b0;
                     snoozing_r <= 1'b0;
                     ring_sec_r <= '0;
                  end else begin
                     ring_sec_r <= ring_sec_r + RING_ONE;
                     ringing_r  <= 1'b1;
                     snoozing_r <= 1'b0;
                  end
               end else begin
                  ringing_r  <= 1'b1;
                  snoozing_r <= 1'b0;
               end
            end
            ST_SNOOZE: begin
               if (!alarm_en || stop_key) begin
                  state_r      <= ST_IDLE;
                  ringing_r    <= 1'b0;
                  snoozing_r   <= 1'b0;
                  snooze_sec_r <= '0;
               end else if (sec_tick) begin
                  if (snooze_sec_r == SSEC_LAST) begin
                     // Back to ringing; snooze_cnt is kept for this event.
                     state_r      <= ST_RING;
                     ringing_r    <= 1'b1;
                     snoozing_r   <= 1'b0;
                     ring_sec_r   <= '0;
                     snooze_sec_r <= '0;
                  end else begin
                     snooze_sec_r <= snooze_sec_r + SSEC_ONE;
                     ringing_r    <= 1'b0;
                     snoozing_r   <= 1'b1;
                  end
               end else begin
                  ringing_r  <= 1'b0;
                  snoozing_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               ringing_r    <= 1'b0;
               snoozing_r   <= 1'b0;
               ring_sec_r   <= '0;
               snooze_sec_r <= '0;
               snooze_cnt_r <= '0;
            end
         endcase
      end
   end

   // The tone generator runs only while the registered state is RING, so
   // its counters are already cleared on the edge that enters RING.
   assign run_s = (state_r == ST_RING);

   alarm_tone_gen #(
      .TONE_DIV    (TONE_DIV),
      .CADENCE_DIV (CADENCE_DIV)
   ) u_tone_gen (
      .clk  (clk),
      .rst  (rst),
      .run  (run_s),
      .buzz (buzzer)
   );

   assign ringing  = ringing_r;
   assign snoozing = snoozing_r;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer
//   Table-driven bench for alarm_ringer with small timing parameters
//   (TONE_DIV=2, CADENCE_DIV=8, RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=1).
//   Each row drives one cycle of inputs and gives the outputs expected just
//   after the following rising edge. Reset behaviour is checked by hand.
module tb_alarm_ringer;

   typedef struct {
      logic en;
      logic m;
      logic t;
      logic stop;
      logic snz;
      logic exp_ring;
      logic exp_snz;
      logic exp_buz;
   } vec_t;

   logic clk;
   logic rst;
   logic alarm_en;
   logic match;
   logic sec_tick;
   logic stop_key;
   logic snooze_key;
   logic buzzer;
   logic ringing;
   logic snoozing;

   vec_t vecs[$];
   int   checks;
   int   failures;
   int   mark;

   alarm_ringer #(
      .TONE_DIV    (2),
      .CADENCE_DIV (8),
      .RING_SEC    (3),
      .SNOOZE_SEC  (2),
      .MAX_SNOOZE  (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alarm_en   (alarm_en),
      .match      (match),
      .sec_tick   (sec_tick),
      .stop_key   (stop_key),
      .snooze_key (snooze_key),
      .buzzer     (buzzer),
      .ringing    (ringing),
      .snoozing   (snoozing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic en, input logic m, input logic t,
                      input logic stop, input logic snz,
                      input logic r, input logic s, input logic b);
      vec_t v;
      v.en = en; v.m = m; v.t = t; v.stop = stop; v.snz = snz;
      v.exp_ring = r; v.exp_snz = s; v.exp_buz = b;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i < last; i++) begin
         @(negedge clk);
         alarm_en   = vecs[i].en;
         match      = vecs[i].m;
         sec_tick   = vecs[i].t;
         stop_key   = vecs[i].stop;
         snooze_key = vecs[i].snz;
         @(posedge clk);
         #1;
         check("ringing",  i, ringing,  vecs[i].exp_ring);
         check("snoozing", i, snoozing, vecs[i].exp_snz);
         check("buzzer",   i, buzzer,   vecs[i].exp_buz);
      end
      @(negedge clk);
      match = 1'b0; sec_tick = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
   endtask

   initial begin
      logic [20:1] pat;
      checks = 0;
      failures = 0;
      rst = 1'b1;
      alarm_en = 1'b0; match = 1'b0; sec_tick = 1'b0;
      stop_key = 1'b0; snooze_key = 1'b0;

      //        en m t st sz   ring snz buz
      // 1: ring and tone/cadence pattern (buzzer on after ring cycles 3,4,7,8,19,20)
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      pat = 20'b11_0000000000_11001100;
      for (int k = 1; k <= 20; k++) add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,pat[k]);
      add(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      // 2: unattended timeout after 3 ticks; buzzer clears one cycle later
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      // 3: snooze, keys ignored in snooze, re-ring, second snooze ignored, stop
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0);
      add(1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0);
      // 4: match while disabled, then enable drop during ring
      add(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      // 5: stop+snooze together; tick at entry not counted; match in ring ignored
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);
      // 6a: ring, use the one snooze, re-ring until the buzzer is high
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1);
      mark = vecs.size();
      // 6b: after reset, snooze allowed again; snooze beats a coincident timeout
      add(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0);
      add(1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1);
      add(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0);

      // Reset state
      #2;
      check("rst_ringing",  -1, ringing,  1'b0);
      check("rst_snoozing", -1, snoozing, 1'b0);
      check("rst_buzzer",   -1, buzzer,   1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_rows(0, mark);

      // Asynchronous reset in the middle of a ring cycle with the buzzer high
      alarm_en = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_ringing",  -2, ringing,  1'b0);
      check("async_rst_snoozing", -2, snoozing, 1'b0);
      check("async_rst_buzzer",   -2, buzzer,   1'b0);
      @(negedge clk);
      rst = 1'b0;

      run_rows(mark, vecs.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Consumer end of the alarm enable line.
- Takes the debounced alarm enable level plus a time-match pulse from the clock/alarm comparator, and drives the buzzer pin with a gated tone pattern.
- Handles stop, snooze (bounded count) and automatic ring timeout.
- Sits between the alarm compare logic and the board buzzer output, alongside the seconds timebase.

Parameters:
- TONE_DIV, 12500, clk cycles per tone half-period (2 kHz at 50 MHz).
- CADENCE_DIV, 12500000, clk cycles per cadence half-period (beep on/off, 0.25 s at 50 MHz).
- RING_SEC, 60, sec_tick pulses before an unattended ring stops.
- SNOOZE_SEC, 300, sec_tick pulses spent in snooze before re-ringing.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- alarm_en  in  1  alarm enable level, from the user key.
- match  in  1  one-cycle pulse when current time equals alarm time.
- sec_tick  in  1  one-cycle 1 Hz pulse from the timebase.
- stop_key  in  1  one-cycle debounced stop press.
- snooze_key  in  1  one-cycle debounced snooze press.
- buzzer  out  1  registered buzzer drive.
- ringing  out  1  high while in RING.
- snoozing  out  1  high while in SNOOZE.

Behaviour:
- Single clock domain; one clock and rst, asynchronous, active-high.
- Reset values: state=IDLE; buzzer, ringing, snoozing = 0; all counters = 0; gate=1; tone=0.
- States: IDLE, RING, SNOOZE. ringing and snoozing are registered decodes of the next state, so they are valid the same cycle state changes.
- Priority in every cycle, highest first: alarm_en==0 > stop_key > snooze_key > timer expiry > match.
- IDLE:
  - match && alarm_en at cycle t -> RING at t+1.
  - Entering RING clears ring_sec, cadence_cnt and tone_cnt; sets gate=1, tone=0; clears snooze_cnt.
- RING:
  - alarm_en==0 or stop_key -> IDLE.
  - snooze_key with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt++; snooze_sec cleared.
  - snooze_key with snooze_cnt==MAX_SNOOZE is ignored.
  - sec_tick with ring_sec==RING_SEC-1 -> IDLE; otherwise sec_tick increments ring_sec.
  - match is ignored (no restart).
- SNOOZE:
  - alarm_en==0 or stop_key -> IDLE; snooze_key and match are ignored.
  - sec_tick with snooze_sec==SNOOZE_SEC-1 -> RING; ring timers and tone cleared, snooze_cnt kept.
  - Otherwise sec_tick increments snooze_sec.
- Tone/cadence (RING only):
  - tone_cnt counts 0..TONE_DIV-1; tone toggles when it wraps.
  - cadence_cnt counts 0..CADENCE_DIV-1; gate toggles when it wraps.
  - buzzer register = tone & gate, so buzzer lags the tone/gate state by one cycle.
  - In IDLE/SNOOZE, counters are held at 0, gate=1, tone=0, buzzer=0 from the cycle after leaving RING.
- Widths: each counter is $clog2(limit) bits, minimum 1. No counter exceeds limit-1; wrap returns to 0.
- Simultaneous events:
  - stop_key+snooze_key -> IDLE.
  - snooze_key+timeout sec_tick in RING -> SNOOZE.
  - match+alarm_en falling in IDLE -> stays IDLE.
- A sec_tick coinciding with RING entry is not counted.
- rst mid-ring forces IDLE and buzzer=0 asynchronously.

Decomposition:
- Shared package/header alarm_defs:
  - state encodings ST_IDLE=2'd0, ST_RING=2'd1, ST_SNOOZE=2'd2;
  - default timing constants at 50 MHz.
- One natural sub-module, alarm_tone_gen:
  - inputs clk, rst, run;
  - TONE_DIV/CADENCE_DIV counters;
  - output tone&gate;
  - counters clear whenever run==0.
- The FSM and the second counters stay in alarm_ringer.

Test Plan:
(params TONE_DIV=2, CADENCE_DIV=8, RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=1)
1. alarm_en=1, match pulse at cycle 10 -> ringing=1 from cycle 11. buzzer toggles with period 4 cycles for 8 cycles, then stays 0 for 8 cycles, repeating.
2. Ringing, 3 sec_tick pulses, no keys -> ringing falls on the cycle after the 3rd tick; buzzer=0 within 1 cycle.
3. Ringing, snooze_key -> snoozing=1, buzzer=0. After 2 sec_ticks -> ringing=1 again. A second snooze_key is ignored (still ringing); stop_key -> IDLE.
4. alarm_en=0 with match pulse -> stays IDLE, buzzer=0. Ringing, then alarm_en drops -> IDLE next cycle.
5. stop_key and snooze_key in the same cycle while ringing -> IDLE, snoozing stays 0. match during RING does not reset ring_sec (timeout still after 3 ticks total).
6. rst asserted mid-ring between clock edges -> buzzer, ringing, snoozing = 0 immediately. After release, match -> rings again with snooze_cnt cleared (snooze allowed).
